// File: rtl/ddr2_tg_pkg.sv
// Shared types and constants for the DDR2 FIFO traffic generator.
// Pattern modes, FSM states, LFSR seed/taps and a busy helper.
package ddr2_tg_pkg;

   typedef enum logic [1:0] {
      PAT_INC  = 2'd0,
      PAT_WALK = 2'd1,
      PAT_LFSR = 2'd2,
      PAT_ALT  = 2'd3
   } pat_mode_e;

   typedef enum logic [2:0] {
      IDLE,
      DELAY,
      WRITE,
      READ,
      DRAIN,
      DONE
   } tg_state_e;

   // x^32 + x^22 + x^2 + x + 1 -> state bits 31, 21, 1, 0
   localparam logic [31:0] LFSR_SEED = 32'h0000_0001;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic is_busy(tg_state_e s);
      return !(s == IDLE || s == DONE);
   endfunction

endpackage

// File: rtl/ddr2_fifo_traffic_gen_if.sv
// FIFO-side bundle between the traffic generator and the DDR2 FIFO.
// master: drives wr_en/wr_data/rd_en; slave: drives full/empty/read data.
interface ddr2_fifo_traffic_gen_if #(
   parameter int DATA_W = 32
) ();

   logic              wr_full;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_empty;
   logic              rd_en;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;

   modport master (
      input  wr_full,
      output wr_en,
      output wr_data,
      input  rd_empty,
      output rd_en,
      input  rd_valid,
      input  rd_data
   );

   modport slave (
      output wr_full,
      input  wr_en,
      input  wr_data,
      output rd_empty,
      input  rd_en,
      output rd_valid,
      output rd_data
   );

endinterface

// File: rtl/ddr2_tg_pat_gen.sv
// Pattern generator: seed_load restarts mode's sequence, advance steps it.
// Ports: clk, reset_n, seed_load, advance, mode, pattern (registered).
module ddr2_tg_pat_gen
   import ddr2_tg_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              seed_load,
   input  logic              advance,
   input  pat_mode_e         mode,
   output logic [DATA_W-1:0] pattern
);

   logic [31:0]       lfsr_q;
   logic [31:0]       lfsr_d;
   logic [DATA_W-1:0] lfsr_w;
   logic [DATA_W-1:0] pat_d;

   function automatic logic [DATA_W-1:0] alt_seed();
      logic [DATA_W-1:0] v;
      v = '0;
      for (int i = 0; i < DATA_W; i++)
         v[i] = 1'(i % 2);
      return v;
   endfunction

   // LFSR always runs on 32 bits; the word is its low bits, zero-extended
   if (DATA_W > 32) begin : g_wide
      assign lfsr_w = {{(DATA_W-32){1'b0}}, lfsr_d};
   end else begin : g_narrow
      assign lfsr_w = lfsr_d[DATA_W-1:0];
   end

   always_comb begin
      lfsr_d = lfsr_q;
      if (seed_load)
         lfsr_d = LFSR_SEED;
      else if (advance && mode == PAT_LFSR)
         lfsr_d = {lfsr_q[30:0], ^(lfsr_q & LFSR_TAPS)};
   end

   always_comb begin
      pat_d = pattern;
      if (seed_load) begin
         unique case (mode)
            PAT_INC:  pat_d = '0;
            PAT_WALK: pat_d = DATA_W'(1);
            PAT_LFSR: pat_d = lfsr_w;
            PAT_ALT:  pat_d = alt_seed();
         endcase
      end else if (advance) begin
         unique case (mode)
            PAT_INC:  pat_d = pattern + 1'b1;
            PAT_WALK: pat_d = {pattern[DATA_W-2:0],
                               pattern[DATA_W-1]};
            PAT_LFSR: pat_d = lfsr_w;
            PAT_ALT:  pat_d = ~pattern;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern <= '0;
         lfsr_q  <= '0;
      end else begin
         pattern <= pat_d;
         lfsr_q  <= lfsr_d;
      end
   end

endmodule

// File: rtl/ddr2_fifo_traffic_gen.sv
// Write/read-back traffic generator and checker for DDR2 FIFO bring-up.
// Ports: clk, reset_n, phy_init_done, mode, fifo (master), busy, done,
// err, err_count, pass_count.
module ddr2_fifo_traffic_gen
   import ddr2_tg_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int BURST_LEN   = 512,
   parameter int START_DELAY = 16,
   parameter int NUM_PASSES  = 0,
   parameter int RD_LAT      = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        phy_init_done,
   input  logic [1:0]  mode,
   ddr2_fifo_traffic_gen_if.master fifo,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] err_count,
   output logic [15:0] pass_count
);

   localparam int CW = $clog2(BURST_LEN + 1);
   localparam int DW = (START_DELAY > 0) ?
                       $clog2(START_DELAY + 1) : 1;

   if (BURST_LEN < 2 || DATA_W < 8 || DATA_W > 64 ||
       RD_LAT < 0) begin : g_bad_param
      $error("ddr2_fifo_traffic_gen: bad parameters");
   end

   tg_state_e         state_q, state_d;
   pat_mode_e         mode_q, mode_d, gen_mode;
   logic [DW-1:0]     dly_q, dly_d;
   logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
   logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
   logic [CW-1:0]     chk_cnt_q, chk_cnt_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;
   logic              seed, pass_end;
   logic              chk_vld, miss;
   logic [DATA_W-1:0] exp_pat;
   int                wr_tot, rd_tot, chk_tot;

   // Words already strobed plus the one in flight this cycle
   always_comb begin
      wr_tot  = int'(wr_cnt_q) + int'(wr_en_q);
      rd_tot  = int'(rd_cnt_q) + int'(rd_en_q);
      chk_vld = fifo.rd_valid &&
                (state_q == READ || state_q == DRAIN);
      chk_tot = int'(chk_cnt_q) + int'(chk_vld);
      miss    = chk_vld && (fifo.rd_data != exp_pat);
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      dly_d     = dly_q;
      wr_cnt_d  = wr_cnt_q + CW'(wr_en_q);
      rd_cnt_d  = rd_cnt_q + CW'(rd_en_q);
      chk_cnt_d = chk_cnt_q + CW'(chk_vld);
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      seed      = 1'b0;
      pass_end  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (phy_init_done) begin
               state_d = DELAY;
               dly_d   = '0;
            end
         end
         DELAY: begin
            if (int'(dly_q) + 1 >= START_DELAY) begin
               state_d   = WRITE;
               mode_d    = pat_mode_e'(mode);
               seed      = 1'b1;
               wr_cnt_d  = '0;
               rd_cnt_d  = '0;
               chk_cnt_d = '0;
            end else begin
               dly_d = dly_q + DW'(1);
            end
         end
         WRITE: begin
            wr_en_d = !fifo.wr_full && wr_tot < BURST_LEN;
            if (wr_tot == BURST_LEN) begin
               state_d  = READ;
               wr_cnt_d = '0;
            end
         end
         READ: begin
            rd_en_d = !fifo.rd_empty && rd_tot < BURST_LEN;
            if (rd_tot == BURST_LEN) begin
               state_d  = DRAIN;
               rd_cnt_d = '0;
            end
         end
         DRAIN: begin
            // Last word is compared on this edge, before the reseed
            if (chk_tot >= BURST_LEN) begin
               pass_end  = 1'b1;
               seed      = 1'b1;
               chk_cnt_d = '0;
               if (NUM_PASSES != 0 &&
                   int'(pass_count) + 1 == NUM_PASSES)
                  state_d = DONE;
               else
                  state_d = WRITE;
            end
         end
         DONE: begin
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         mode_q     <= PAT_INC;
         dly_q      <= '0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         chk_cnt_q  <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         err        <= 1'b0;
         err_count  <= '0;
         pass_count <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         dly_q     <= dly_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         chk_cnt_q <= chk_cnt_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         if (miss) begin
            err <= 1'b1;
            if (err_count != 16'hFFFF)
               err_count <= err_count + 16'd1;
         end
         if (pass_end)
            pass_count <= pass_count + 16'd1;
      end
   end

   // Mode is taken live on the DELAY exit edge, latched afterwards
   assign gen_mode = (state_q == DELAY) ?
                     pat_mode_e'(mode) : mode_q;

   ddr2_tg_pat_gen #(.DATA_W(DATA_W)) u_wr_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .seed_load (seed),
      .advance   (wr_en_q),
      .mode      (gen_mode),
      .pattern   (fifo.wr_data)
   );

   ddr2_tg_pat_gen #(.DATA_W(DATA_W)) u_exp_gen (
      .clk       (clk),
      .reset_n   (reset_n),
      .seed_load (seed),
      .advance   (chk_vld),
      .mode      (gen_mode),
      .pattern   (exp_pat)
   );

   assign fifo.wr_en = wr_en_q;
   assign fifo.rd_en = rd_en_q;
   assign busy       = is_busy(state_q);
   assign done       = (state_q == DONE);

endmodule

// File: tb/tb_ddr2_fifo_traffic_gen.sv
// Directed bench for ddr2_fifo_traffic_gen with ideal FIFO models.
// u_dut1: defaults (32b, endless); u_dut2: 8b walking-one, two passes.
module tb_ddr2_fifo_traffic_gen;
   import ddr2_tg_pkg::*;

   logic        clk = 1'b0;
   logic        rst1_n, rst2_n, init1, init2;
   logic [1:0]  mode1, mode2;
   logic        busy1, done1, err1, busy2, done2, err2;
   logic [15:0] ec1, pc1, ec2, pc2;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ddr2_fifo_traffic_gen_if #(.DATA_W(32)) if1 ();
   ddr2_fifo_traffic_gen_if #(.DATA_W(8))  if2 ();

   ddr2_fifo_traffic_gen u_dut1 (
      .clk(clk), .reset_n(rst1_n), .phy_init_done(init1),
      .mode(mode1), .fifo(if1), .busy(busy1), .done(done1),
      .err(err1), .err_count(ec1), .pass_count(pc1)
   );

   ddr2_fifo_traffic_gen #(.DATA_W(8), .NUM_PASSES(2)) u_dut2 (
      .clk(clk), .reset_n(rst2_n), .phy_init_done(init2),
      .mode(mode2), .fifo(if2), .busy(busy2), .done(done2),
      .err(err2), .err_count(ec2), .pass_count(pc2)
   );

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // ---------------- dut1 FIFO model ----------------
   logic [31:0] q1 [$];
   logic [31:0] pop1, d1a, d1b;
   logic        v1a, v1b, b1a, b1b, bad;
   logic        tog1, corrupt, stray1, chk_inc;
   int          ridx1;

   always @(posedge clk or negedge rst1_n) begin
      if (!rst1_n) begin
         q1.delete();
         v1a <= 1'b0; v1b <= 1'b0;
         b1a <= 1'b0; b1b <= 1'b0;
         d1a <= '0;   d1b <= '0;
         ridx1 <= 0;
         if1.rd_empty <= 1'b0;
      end else begin
         if (if1.wr_en) q1.push_back(if1.wr_data);
         v1a <= if1.rd_en; v1b <= v1a;
         b1a <= 1'b0;      b1b <= b1a;
         d1b <= d1a;
         if (if1.rd_en) begin
            if (q1.size() > 0) pop1 = q1.pop_front();
            else pop1 = '0;
            bad = corrupt && ridx1 == 7;
            d1a <= bad ? (pop1 ^ 32'h1) : pop1;
            b1a <= bad;
            ridx1 <= (ridx1 == 511) ? 0 : ridx1 + 1;
         end
         if1.rd_empty <= tog1 ? !if1.rd_empty : 1'b0;
      end
   end

   assign if1.rd_valid = v1b | stray1;
   assign if1.rd_data  = stray1 ? 32'hDEAD_BEEF : d1b;

   // dut1 monitors
   int          nwr1, nrd1, widx1, seq_err1, stall_wr;
   logic        fprev;
   logic [31:0] first4 [4];
   int          bad_cyc = 0;
   int          err_cyc = 0;

   always @(posedge clk or negedge rst1_n) begin
      if (!rst1_n) begin
         nwr1 <= 0; nrd1 <= 0; widx1 <= 0;
         seq_err1 <= 0; stall_wr <= 0; fprev <= 1'b0;
      end else begin
         fprev <= if1.wr_full;
         if (if1.wr_en && fprev) stall_wr <= stall_wr + 1;
         if (if1.rd_en) nrd1 <= nrd1 + 1;
         if (if1.wr_en) begin
            nwr1 <= nwr1 + 1;
            if (chk_inc && if1.wr_data != 32'(widx1))
               seq_err1 <= seq_err1 + 1;
            if (widx1 < 4) first4[widx1] <= if1.wr_data;
            widx1 <= (widx1 == 511) ? 0 : widx1 + 1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (if1.rd_valid && b1b) bad_cyc = cyc;
      if (err1 && err_cyc == 0) err_cyc = cyc;
   end

   // ---------------- dut2 FIFO model ----------------
   logic [7:0] q2 [$];
   logic [7:0] pop2, d2a, d2b;
   logic       v2a, v2b;
   int         nwr2, nrd2, widx2, walk_err;

   always @(posedge clk or negedge rst2_n) begin
      if (!rst2_n) begin
         q2.delete();
         v2a <= 1'b0; v2b <= 1'b0;
         d2a <= '0;   d2b <= '0;
         nwr2 <= 0; nrd2 <= 0; widx2 <= 0; walk_err <= 0;
      end else begin
         v2a <= if2.rd_en; v2b <= v2a; d2b <= d2a;
         if (if2.wr_en) begin
            q2.push_back(if2.wr_data);
            nwr2 <= nwr2 + 1;
            if (if2.wr_data != 8'(1 << (widx2 % 8)))
               walk_err <= walk_err + 1;
            widx2 <= (widx2 == 511) ? 0 : widx2 + 1;
         end
         if (if2.rd_en) begin
            if (q2.size() > 0) pop2 = q2.pop_front();
            else pop2 = '0;
            d2a <= pop2;
            nrd2 <= nrd2 + 1;
         end
      end
   end

   assign if2.rd_valid = v2b;
   assign if2.rd_data  = d2b;
   assign if2.rd_empty = 1'b0;
   assign if2.wr_full  = 1'b0;

   // ---------------- directed sequence ----------------
   int lat;

   initial begin
      rst1_n = 1'b0; rst2_n = 1'b0;
      init1 = 1'b0;  init2 = 1'b0;
      mode1 = 2'd0;  mode2 = 2'd1;
      if1.wr_full = 1'b0;
      tog1 = 1'b0; corrupt = 1'b0;
      stray1 = 1'b0; chk_inc = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst1_n = 1'b1; rst2_n = 1'b1;
      @(posedge clk); #1;
      check("rst_wr_en", if1.wr_en, 0);
      check("rst_rd_en", if1.rd_en, 0);
      check("rst_wr_data", if1.wr_data, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_err", err1, 0);
      check("rst_err_cnt", ec1, 0);
      check("rst_pass_cnt", pc1, 0);

      // stray read data while idle must be ignored
      stray1 = 1'b1;
      repeat (3) @(posedge clk);
      #1 stray1 = 1'b0;
      @(posedge clk); #1;
      check("stray_err", err1, 0);
      check("stray_err_cnt", ec1, 0);
      check("stray_busy", busy1, 0);

      // mode 0 pass: 1 sample + 16 delay + 1 register = 18
      init1 = 1'b1;
      lat = 0;
      for (int i = 1; i <= 100 && lat == 0; i++) begin
         @(posedge clk); #1;
         if (if1.wr_en) lat = i;
      end
      init1 = 1'b0;
      check("first_wr_lat", lat, 18);
      for (int i = 0; i < 3000 && pc1 != 1; i++) begin
         @(posedge clk); #1;
      end
      check("p1_pass_cnt", pc1, 1);
      check("p1_writes", nwr1, 512);
      check("p1_reads", nrd1, 512);
      check("p1_wr_seq", seq_err1, 0);
      check("p1_err", err1, 0);
      check("p1_busy", busy1, 1);

      // stall for 10 cycles after write 200 of pass 2
      for (int i = 0; i < 1000 && nwr1 < 712; i++) begin
         @(posedge clk); #1;
      end
      if1.wr_full = 1'b1;
      repeat (10) @(posedge clk);
      #1 if1.wr_full = 1'b0;
      for (int i = 0; i < 3000 && pc1 != 2; i++) begin
         @(posedge clk); #1;
      end
      check("p2_pass_cnt", pc1, 2);
      check("p2_writes", nwr1, 1024);
      check("p2_stall_wr", stall_wr, 0);
      check("p2_wr_seq", seq_err1, 0);
      check("p2_err_cnt", ec1, 0);

      // reset at write 300 of pass 3
      for (int i = 0; i < 1000 && nwr1 < 1324; i++) begin
         @(posedge clk); #1;
      end
      rst1_n = 1'b0;
      init1 = 1'b1;
      #1;
      check("mid_rst_wr_en", if1.wr_en, 0);
      check("mid_rst_rd_en", if1.rd_en, 0);
      check("mid_rst_wr_data", if1.wr_data, 0);
      check("mid_rst_busy", busy1, 0);
      check("mid_rst_pass", pc1, 0);
      mode1 = 2'd2; corrupt = 1'b1;
      tog1 = 1'b1; chk_inc = 1'b0;
      @(posedge clk);
      #1 rst1_n = 1'b1;
      @(posedge clk); #1;
      check("restart_busy", busy1, 1);
      check("restart_wr_data", if1.wr_data, 0);

      // LFSR pass, word 7 corrupted, rd_empty toggling
      for (int i = 0; i < 5000 && pc1 != 1; i++) begin
         @(posedge clk); #1;
      end
      check("lfsr_pass_cnt", pc1, 1);
      check("lfsr_reads", nrd1, 512);
      check("lfsr_writes", nwr1, 512);
      check("lfsr_w0", first4[0], 32'h1);
      check("lfsr_w1", first4[1], 32'h3);
      check("lfsr_w2", first4[2], 32'h6);
      check("lfsr_w3", first4[3], 32'hD);
      check("lfsr_err", err1, 1);
      check("lfsr_err_cnt", ec1, 1);
      check("bad_seen", bad_cyc != 0, 1);
      check("err_delay", err_cyc - bad_cyc, 1);
      tog1 = 1'b0; corrupt = 1'b0;

      // dut2: 8-bit walking one, two passes then DONE
      init2 = 1'b1;
      for (int i = 0; i < 6000 && !done2; i++) begin
         @(posedge clk); #1;
      end
      check("d2_done", done2, 1);
      check("d2_busy", busy2, 0);
      check("d2_pass_cnt", pc2, 2);
      check("d2_err", err2, 0);
      check("d2_writes", nwr2, 1024);
      check("d2_reads", nrd2, 1024);
      check("d2_walk_seq", walk_err, 0);
      repeat (40) @(posedge clk);
      #1;
      check("d2_idle_wr", nwr2, 1024);
      check("d2_idle_rd", nrd2, 1024);
      check("d2_done_hold", done2, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
